// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
//   loader_state_t  : loader FSM states (CSUM exists only with IMEM_LOADER_CHECKSUM_EN)
//   HDR_BYTES       : bytes in the word-count header
//   BYTES_PER_WORD  : bytes packed into one 32-bit instruction word
//   CSUM_INIT       : starting value of the running XOR checksum
// Configuration macro: IMEM_LOADER_CHECKSUM_EN (adds the trailing checksum byte).
package imem_loader_pkg;

  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [7:0] CSUM_INIT = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CSUM   = 3'd4,
`endif
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } loader_state_t;

  // Running checksum step: XOR of every data byte.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // States in which the loader takes bytes from the host channel.
  function automatic logic accepts_bytes(input loader_state_t s);
    logic r;
    case (s)
      ST_HDR_HI, ST_HDR_LO, ST_DATA: r = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM:                       r = 1'b1;
`endif
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte channel plus instruction-memory write port.
//   in_valid/in_data/in_ready : byte stream, transfer on in_valid && in_ready
//   mem_we/mem_addr/mem_wdata : one-cycle word write strobe, word address, word data
//   modport master : host / memory side (drives bytes, observes writes)
//   modport slave  : loader side
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, output in_data, input in_ready,
    input mem_we, input mem_addr, input mem_wdata
  );

  modport slave (
    input in_valid, input in_data, output in_ready,
    output mem_we, output mem_addr, output mem_wdata
  );
endinterface

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: packs bytes big-endian into 32-bit words.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of shift register and byte counter
//   push       : shift din in from the LSB end
//   din        : byte to push
//   word       : registered shift register; holds the completed word the cycle after word_done
//   word_done  : this push completes a word (combinational)
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_done
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [31:0] shift_r;
  logic [1:0]  cnt_r;

  // Shift register and byte counter; counter wraps to 0 after the 4th byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= 32'h0000_0000;
      cnt_r   <= 2'd0;
    end else if (clr) begin
      shift_r <= 32'h0000_0000;
      cnt_r   <= 2'd0;
    end else if (push) begin
      shift_r <= {shift_r[23:0], din};
      cnt_r   <= cnt_r + 2'd1;
    end
  end

  assign word_done = push && (cnt_r == LAST_LANE);
  assign word      = shift_r;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a program image (16-bit word count, 4*N data bytes,
// optional XOR checksum byte) into instruction memory and holds the CPU in
// reset until a complete image is in place.
//   clk, rst_n : clock, async active-low reset
//   start      : single-cycle pulse, re-arms from DONE or ERROR
//   bus        : imem_loader_if.slave (byte channel + memory write port)
//   cpu_hold   : CPU held in reset while high
//   done       : image loaded (and checksum matched when enabled)
//   error      : image rejected
// Configuration macro: IMEM_LOADER_CHECKSUM_EN -- when defined, a checksum
// byte follows the data and is verified in a CSUM state; otherwise DONE is
// entered directly with the final write.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

  localparam int HDR_BITS = HDR_BYTES * 8;
  localparam logic [HDR_BITS:0] DEPTH_W = (HDR_BITS + 1)'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t ST_AFTER_DATA = ST_CSUM;
`else
  localparam loader_state_t ST_AFTER_DATA = ST_DONE;
`endif

  loader_state_t       state_r, state_nx_s;
  logic                accept_s, push_s, clr_s, word_done_s, last_word_s;
  logic [HDR_BITS-1:0] hdr_n_s, n_r, words_r;
  logic [7:0]          hdr_hi_r;
  logic [31:0]         word_s;
  logic                in_ready_r, done_r, error_r, cpu_hold_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_r;
`endif

  assign accept_s    = bus.in_valid && in_ready_r;
  assign push_s      = accept_s && (state_r == ST_DATA);
  assign clr_s       = start && ((state_r == ST_DONE) || (state_r == ST_ERROR));
  assign hdr_n_s     = {hdr_hi_r, bus.in_data};
  assign last_word_s = ((words_r + 16'd1) == n_r);

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr_s),
    .push      (push_s),
    .din       (bus.in_data),
    .word      (word_s),
    .word_done (word_done_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: state_nx_s = ST_HDR_HI;
      ST_HDR_HI: begin
        if (accept_s) state_nx_s = ST_HDR_LO;
        else          state_nx_s = ST_HDR_HI;
      end
      ST_HDR_LO: begin
        // Size is checked before any write, so addresses can never wrap.
        if (!accept_s)                        state_nx_s = ST_HDR_LO;
        else if ({1'b0, hdr_n_s} > DEPTH_W)   state_nx_s = ST_ERROR;
        else if (hdr_n_s == 16'd0)            state_nx_s = ST_AFTER_DATA;
        else                                  state_nx_s = ST_DATA;
      end
      ST_DATA: begin
        if (word_done_s && last_word_s) state_nx_s = ST_AFTER_DATA;
        else                            state_nx_s = ST_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (!accept_s)                   state_nx_s = ST_CSUM;
        else if (bus.in_data == csum_r)  state_nx_s = ST_DONE;
        else                             state_nx_s = ST_ERROR;
      end
`endif
      ST_DONE, ST_ERROR: begin
        if (start) state_nx_s = ST_HDR_HI;
        else       state_nx_s = state_r;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Header capture, word index, checksum and write strobe/address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_hi_r   <= 8'h00;
      n_r        <= 16'd0;
      words_r    <= 16'd0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r     <= CSUM_INIT;
`endif
    end else begin
      mem_we_r <= 1'b0;
      if (clr_s) begin
        hdr_hi_r <= 8'h00;
        n_r      <= 16'd0;
        words_r  <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_r   <= CSUM_INIT;
`endif
      end else begin
        if (accept_s && (state_r == ST_HDR_HI)) hdr_hi_r <= bus.in_data;
        if (accept_s && (state_r == ST_HDR_LO)) n_r <= hdr_n_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (push_s) csum_r <= csum_update(csum_r, bus.in_data);
`endif
        if (word_done_s) begin
          mem_we_r   <= 1'b1;
          mem_addr_r <= words_r[ADDR_W-1:0];
          words_r    <= words_r + 16'd1;
        end
      end
    end
  end

  // Status outputs registered from the next state so they change with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      cpu_hold_r <= 1'b1;
    end else begin
      in_ready_r <= accepts_bytes(state_nx_s);
      done_r     <= (state_nx_s == ST_DONE);
      error_r    <= (state_nx_s == ST_ERROR);
      cpu_hold_r <= (state_nx_s != ST_DONE);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = word_s;
  assign done          = done_r;
  assign error         = error_r;
  assign cpu_hold      = cpu_hold_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed + randomized image streams checked against a
// stream-level model (word list, XOR checksum, size limit).
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done, error;
  int   checks   = 0;
  int   errors   = 0;
  int   wr_count = 0;
  logic [7:0] stream_q[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Count every write strobe seen on the memory port.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) wr_count <= wr_count + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {22'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
  endtask

  // Present one byte (after optional idle gap) and wait until it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n;
    if (gap_max > 0 && $urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(1, gap_max)) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_done", {31'd0, done}, 32'd0);
    chk("start_error", {31'd0, error}, 32'd0);
    chk("start_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("start_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Send stream_q and check writes and outcome against the image rules.
  task automatic run_stream(input int gap_max);
    int n_words, wr0, k;
    logic [7:0] x;
    logic ok;
    n_words = {stream_q[0], stream_q[1]};
    wr0 = wr_count;
    if (n_words > DEPTH) begin
      send_byte(stream_q[0], gap_max);
      send_byte(stream_q[1], gap_max);
      chk("hdr_error", {31'd0, error}, 32'd1);
      chk("hdr_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      chk("hdr_done", {31'd0, done}, 32'd0);
      chk("hdr_in_ready", {31'd0, bus.in_ready}, 32'd0);
      repeat (4) @(negedge clk);
      chk("hdr_no_write", wr_count - wr0, 32'd0);
      return;
    end
    x = 8'h00;
    for (int i = 2; i < 2 + 4 * n_words; i++) x = x ^ stream_q[i];
    ok = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    ok = (stream_q[stream_q.size() - 1] == x);
`endif
    for (int i = 0; i < stream_q.size(); i++) begin
      send_byte(stream_q[i], gap_max);
      if (i >= 2 && i < 2 + 4 * n_words && ((i - 2) % 4) == 3) begin
        k = (i - 2) / 4;
        chk("wr_we", {31'd0, bus.mem_we}, 32'd1);
        chk("wr_addr", {22'd0, bus.mem_addr}, k);
        chk("wr_data", bus.mem_wdata,
            {stream_q[i - 3], stream_q[i - 2], stream_q[i - 1], stream_q[i]});
      end
    end
    chk("end_done", {31'd0, done}, {31'd0, ok});
    chk("end_error", {31'd0, error}, {31'd0, !ok});
    chk("end_cpu_hold", {31'd0, cpu_hold}, {31'd0, !ok});
    chk("end_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk("wr_count", wr_count - wr0, n_words);
  endtask

  task automatic load_stream1(input logic [7:0] last);
    stream_q = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h10, 8'h21, 8'h09, 8'h00, 8'h01};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream_q.push_back(last);
`else
    if (last == 8'hFF) stream_q.push_back(last);
`endif
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Power-on reset.
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    chk("rel_in_ready0", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk("rel_in_ready1", {31'd0, bus.in_ready}, 32'd1);

    // Two-word image with correct checksum.
    load_stream1(8'h0D);
    run_stream(0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Same image with a corrupted checksum.
    pulse_start();
    load_stream1(8'h0E);
    run_stream(0);
`endif

    // Oversized header N=1025.
    pulse_start();
    stream_q = '{8'h04, 8'h01};
    run_stream(0);

    // Reset in the middle of a load, then the full image again.
    pulse_start();
    load_stream1(8'h0D);
    for (int i = 0; i < 5; i++) send_byte(stream_q[i], 0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_in_ready", {31'd0, bus.in_ready}, 32'd1);
    run_stream(0);

    // start together with in_valid in DONE: the byte must be ignored.
    start        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    @(negedge clk);
    start        = 1'b0;
    bus.in_valid = 1'b0;
    chk("sv_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("sv_done", {31'd0, done}, 32'd0);
    chk("sv_in_ready", {31'd0, bus.in_ready}, 32'd1);
    stream_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream_q.push_back(8'h00);
`endif
    run_stream(0);

    // Full-depth image with idle gaps.
    pulse_start();
    stream_q = '{8'h04, 8'h00};
    for (int i = 0; i < 4 * DEPTH; i++) stream_q.push_back(8'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream_q.push_back(8'h00);
`endif
    run_stream(3);

    // Random small images, some with a corrupted checksum.
    for (int r = 0; r < 4; r++) begin
      int n;
      logic [7:0] x, b;
      pulse_start();
      n = $urandom_range(0, 6);
      stream_q = {};
      stream_q.push_back(8'(n >> 8));
      stream_q.push_back(8'(n));
      x = 8'h00;
      for (int j = 0; j < 4 * n; j++) begin
        b = 8'($urandom);
        x = x ^ b;
        stream_q.push_back(b);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if ($urandom_range(0, 1) == 1) x = x ^ 8'h5A;
      stream_q.push_back(x);
`endif
      run_stream(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
